neocore_elastic_stage: RTL and testbench

- Parametrised, elastic replacement for the fixed-payload stage registers between IF/ID/EX/MEM/WB.
- Carries an opaque packed payload of DATA_W bits through a DEPTH-entry in-order buffer.
- Uses a valid/ready handshake instead of a raw stall input, with flush and hold controls.
- in_ready is registered, so no combinational path exists from out_ready to in_ready; this breaks the global stall chain while still sustaining one beat per cycle.

---
 rtl/neocore_elastic_stage.sv | 106 ++++++++++
 tb/tb_neocore_elastic_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/neocore_elastic_stage.sv
// Elastic pipeline stage: DEPTH-entry in-order buffer with a valid/ready handshake,
// flush and hold controls. in_ready_o is registered, which keeps out_ready_i off
// any combinational path to in_ready_o.
module neocore_elastic_stage #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned DEPTH     = 2,
    parameter bit          ZERO_IDLE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    input  logic                       flush_i,
    input  logic                       hold_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_ready_q, in_ready_d;

    logic push, pop;
    logic out_valid;

    assign out_valid = (count_q != '0) && !hold_i;
    assign push      = in_valid_i && in_ready_q && !flush_i;
    assign pop       = out_valid && out_ready_i;

    // Next-state pointers, occupancy and registered ready.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        in_ready_d = in_ready_q;
        if (flush_i) begin
            // A same-cycle pop has already completed downstream; nothing to undo.
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            in_ready_d = 1'b1;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
            // Derived from next-state count so push and pop can overlap every cycle.
            in_ready_d = (count_d < DepthCnt);
        end
    end

    // Control state register; reset dominates flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Payload storage: cleared on reset, otherwise written only on an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    // Output drive: head slot, optionally blanked while idle.
    always_comb begin
        out_data_o = mem_q[rd_ptr_q];
        if (ZERO_IDLE && !out_valid) begin
            out_data_o = '0;
        end
    end

    assign out_valid_o = out_valid;
    assign in_ready_o  = in_ready_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_neocore_elastic_stage.sv
// Bench for neocore_elastic_stage: a DEPTH=2 and a DEPTH=4 instance share one stimulus
// stream; each has a queue-based scoreboard that also predicts ready/valid/count.
module tb_neocore_elastic_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       flush = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic       rdy2, ov2, rdy4, ov4;
    logic [7:0] od2, od4;
    logic [1:0] cnt2;
    logic [2:0] cnt4;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    bit          checking = 1'b0;

    logic [7:0] sb2[$];
    logic [7:0] sb4[$];
    bit         mrdy2 = 1'b0;
    bit         mrdy4 = 1'b0;
    bit         push4_last = 1'b0;

    always #5 clk = ~clk;

    neocore_elastic_stage #(.DATA_W(8), .DEPTH(2), .ZERO_IDLE(1'b1)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_ready_o (rdy2),
        .in_data_i  (in_data),
        .out_valid_o(ov2),
        .out_ready_i(out_ready),
        .out_data_o (od2),
        .flush_i    (flush),
        .hold_i     (hold),
        .count_o    (cnt2)
    );

    neocore_elastic_stage #(.DATA_W(8), .DEPTH(4), .ZERO_IDLE(1'b1)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_ready_o (rdy4),
        .in_data_i  (in_data),
        .out_valid_o(ov4),
        .out_ready_i(out_ready),
        .out_data_o (od4),
        .flush_i    (flush),
        .hold_i     (hold),
        .count_o    (cnt4)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: compare DUT outputs with the scoreboards, then advance the models.
    task automatic tick();
        bit         ev2, ev4, pu2, pu4, po2, po4;
        logic [7:0] ed2, ed4;
        #1;
        ev2 = (sb2.size() != 0) && !hold;
        ev4 = (sb4.size() != 0) && !hold;
        ed2 = ev2 ? sb2[0] : 8'h00;
        ed4 = ev4 ? sb4[0] : 8'h00;
        if (checking) begin
            check_eq("d2.in_ready",  32'(rdy2), 32'(mrdy2));
            check_eq("d2.out_valid", 32'(ov2),  32'(ev2));
            check_eq("d2.out_data",  32'(od2),  32'(ed2));
            check_eq("d2.count",     32'(cnt2), 32'(sb2.size()));
            check_eq("d4.in_ready",  32'(rdy4), 32'(mrdy4));
            check_eq("d4.out_valid", 32'(ov4),  32'(ev4));
            check_eq("d4.out_data",  32'(od4),  32'(ed4));
            check_eq("d4.count",     32'(cnt4), 32'(sb4.size()));
        end
        pu2 = in_valid && mrdy2 && !flush;
        pu4 = in_valid && mrdy4 && !flush;
        po2 = ev2 && out_ready;
        po4 = ev4 && out_ready;
        @(posedge clk);
        if (rst) begin
            sb2.delete();
            sb4.delete();
            mrdy2 = 1'b0;
            mrdy4 = 1'b0;
        end else if (flush) begin
            // Any same-cycle pop was consumed; everything left is discarded.
            sb2.delete();
            sb4.delete();
            mrdy2 = 1'b1;
            mrdy4 = 1'b1;
        end else begin
            if (po2) void'(sb2.pop_front());
            if (po4) void'(sb4.pop_front());
            if (pu2) sb2.push_back(in_data);
            if (pu4) sb4.push_back(in_data);
            mrdy2 = (sb2.size() < 2);
            mrdy4 = (sb4.size() < 4);
        end
        push4_last = pu4 && !rst;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Offer one beat until the DEPTH=4 model accepts it, within a bounded number of cycles.
    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (push4_last) break;
        end
        if (!push4_last) check_eq("send.timeout", 32'(push4_last), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        // 1: reset with in_valid asserted, then release.
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        tick();
        checking = 1'b1;
        ticks(2);
        rst = 1'b0;
        in_valid = 1'b0;
        ticks(2);

        // 2: full-rate streaming with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h11 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        ticks(3);

        // 3: backpressure until full, then drain across the pointer wrap.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA1 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(8'hA5 + 8'(i));
        ticks(6);

        // 4: flush with a pop and a push in the same cycle.
        out_ready = 1'b0;
        send(8'hB1);
        send(8'hB2);
        in_valid = 1'b1;
        in_data = 8'hB3;
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        ticks(2);

        // 5: hold freezes the output while pushes continue.
        out_ready = 1'b0;
        send(8'hC1);
        hold = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hC2;
        tick();
        in_data = 8'hC3;
        tick();
        in_valid = 1'b0;
        tick();
        hold = 1'b0;
        ticks(5);

        // 6: reset mid-stream drops all beats.
        out_ready = 1'b0;
        send(8'hE1);
        send(8'hE2);
        send(8'hE3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(8'hD1);
        tick();
        out_ready = 1'b1;
        ticks(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
